matmul_arbiter: RTL
===================

Name: matmul_arbiter

Overview:
- Round-robin arbiter that time-shares one matmul datapath between NUM_REQ requesters, such as RNN gate units.
- Grants one requester at a time and routes that requester's data1/data2 operands and sel into the matmul.
- Issues a single-cycle start to the matmul, waits for it to finish, then holds the grant for a readout phase.
- The readout phase lasts until the requester releases it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA1_LEN_BITS, 2, width of matmul sel_vec.
- DATA2_ROW_BITS, 2, width of matmul sel_row.
- DATA2_COL_BITS, 4, width of matmul sel/sel_col.
- TIMEOUT, 64, readout watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  request bit per requester, level
- rel  in  NUM_REQ  release bit per requester; ends its readout
- req_data1  in  NUM_REQ*16  packed per-requester data1 operand
- req_data2  in  NUM_REQ*16  packed per-requester data2 operand
- req_sel  in  NUM_REQ*DATA2_COL_BITS  packed per-requester readout select
- grant  out  NUM_REQ  one-hot grant, registered
- done  out  NUM_REQ  one-cycle pulse to the granted requester when its result is readable
- busy  out  1  high whenever state is not IDLE
- sel_vec  out  DATA1_LEN_BITS  matmul sel_vec, broadcast to requesters for operand addressing
- sel_row  out  DATA2_ROW_BITS  matmul sel_row, broadcast
- sel_col  out  DATA2_COL_BITS  matmul sel_col, broadcast
- data_out  out  16  matmul data_out, broadcast
- mm_start  out  1  start to the matmul
- mm_ready  in  1  matmul ready
- mm_data1  out  16  operand to the matmul
- mm_data2  out  16  operand to the matmul
- mm_sel  out  DATA2_COL_BITS  readout select to the matmul
- mm_data_out  in  16  result from the matmul
- mm_sel_vec  in  DATA1_LEN_BITS  address from the matmul
- mm_sel_row  in  DATA2_ROW_BITS  address from the matmul
- mm_sel_col  in  DATA2_COL_BITS  address from the matmul

Behaviour:
- Reset:
  - Reset is asynchronous and active-high.
  - On reset: state=IDLE, grant=0, done=0, mm_start=0, priority pointer=0 (requester 0 highest priority).
- State machine:
  - IDLE: when req!=0 and mm_ready=1, register a one-hot grant to the first requesting index at or after the pointer, wrapping modulo NUM_REQ; go to START. Otherwise stay in IDLE.
  - START: mm_start=1 for exactly this cycle; go to WAIT_LO.
  - WAIT_LO: wait for mm_ready=0 (matmul accepted start); go to WAIT_HI.
  - WAIT_HI: wait for mm_ready=1; done[g]=1 for one cycle on the transition; go to READOUT.
  - READOUT: when rel[g]=1, clear grant, set pointer=(g+1) mod NUM_REQ, return to IDLE.
- Latency: req sampled in cycle N gives grant and mm_start visible in cycle N+1. The earliest new grant is the cycle after release.
- Muxing:
  - While grant!=0: mm_data1/mm_data2/mm_sel come from the granted slice.
  - When grant=0: mm_data1/mm_data2/mm_sel are 0.
  - sel_vec/sel_row/sel_col/data_out pass combinationally from the mm_* inputs.
- Boundaries:
  - req dropping mid-operation is ignored; the grant holds until rel.
  - rel while not in READOUT is ignored.
  - rel from a non-granted requester is ignored.
  - Simultaneous requests are resolved by the pointer only.
  - A requester whose req stays high after release is re-granted only after the other pending requesters (fairness).
  - mm_ready=0 in IDLE blocks granting.
  - Reset mid-operation returns to IDLE immediately; mm_start drops the same cycle.
- Invariant: grant is always one-hot or zero.

Optional Feature:
- Macro: MATMUL_ARB_TIMEOUT_EN.
- When defined:
  - A readout counter runs in READOUT.
  - If no rel arrives within TIMEOUT cycles, the grant is force-released and the pointer advances.
  - A sticky output port timeout_err (1 bit, reset 0) is set; it is cleared only by rst.
- When undefined: no counter, no timeout_err port, and READOUT waits indefinitely.

Test Plan:
- Reset, then req=0001, mm_ready=1 -> grant=0001 and mm_start pulse on the next cycle. With a matmul model dropping ready for 10 cycles, done=0001 pulses once when ready returns. rel[0] -> grant=0000 and busy=0.
- req=0101 held from reset -> grant order 0001, 0100, 0001 across three operations. The pointer is observed as 1, 3, 1 after each release.
- Granted requester 2 with req_data1=0x0100, req_data2=0x0300 -> mm_data1=0x0100 and mm_data2=0x0300. In READOUT, req_sel[2]=5 gives mm_sel=5, and data_out equals mm_data_out.
- Requester 1 asserts rel during WAIT_HI, and req[0] drops during START -> both ignored; the FSM completes normally and grant is unchanged until a valid rel.
- Assert rst in WAIT_LO -> grant=0, mm_start=0, done=0, busy=0 asynchronously; the next req=1000 is granted first because the pointer has reset to 0.
- MATMUL_ARB_TIMEOUT_EN with TIMEOUT=16 and rel never asserted -> grant clears 16 cycles after entering READOUT, timeout_err=1 and stays set, and the next requester is granted.

Source files
------------

// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one matmul among NUM_REQ requesters; optional readout watchdog via MATMUL_ARB_TIMEOUT_EN.
// Latency: req in cycle N -> grant/mm_start in N+1; holds grant until rel (mm_ready=0 in IDLE blocks granting).
module matmul_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA1_LEN_BITS = 2,
    parameter int DATA2_ROW_BITS = 2,
    parameter int DATA2_COL_BITS = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0]                 rel,
    input  logic [NUM_REQ*16-1:0]              req_data1,
    input  logic [NUM_REQ*16-1:0]              req_data2,
    input  logic [NUM_REQ*DATA2_COL_BITS-1:0]  req_sel,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [NUM_REQ-1:0]                 done,
    output logic                               busy,
    output logic [DATA1_LEN_BITS-1:0]          sel_vec,
    output logic [DATA2_ROW_BITS-1:0]          sel_row,
    output logic [DATA2_COL_BITS-1:0]          sel_col,
    output logic [15:0]                        data_out,
    output logic                               mm_start,
    input  logic                               mm_ready,
    output logic [15:0]                        mm_data1,
    output logic [15:0]                        mm_data2,
    output logic [DATA2_COL_BITS-1:0]          mm_sel,
    input  logic [15:0]                        mm_data_out,
    input  logic [DATA1_LEN_BITS-1:0]          mm_sel_vec,
    input  logic [DATA2_ROW_BITS-1:0]          mm_sel_row,
    input  logic [DATA2_COL_BITS-1:0]          mm_sel_col
`ifdef MATMUL_ARB_TIMEOUT_EN
    ,
    output logic                               timeout_err
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LO,
        WAIT_HI,
        READOUT
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [PTR_W-1:0]     g_idx;
    logic [PTR_W-1:0]     ptr_next;
    logic                 rel_g;

`ifdef MATMUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tout_q, tout_d;
`endif

    // First requester at or after the pointer, wrapping.
    always_comb begin : pick_blk
        logic found;
        int   idx;
        pick_oh = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                pick_oh[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Grant is one-hot, so OR-ing masked slices selects the owner (zero when idle).
    always_comb begin
        g_idx    = '0;
        mm_data1 = '0;
        mm_data2 = '0;
        mm_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx = PTR_W'(i);
            end
            mm_data1 = mm_data1 | (req_data1[i*16 +: 16] & {16{grant_q[i]}});
            mm_data2 = mm_data2 | (req_data2[i*16 +: 16] & {16{grant_q[i]}});
            mm_sel   = mm_sel | (req_sel[i*DATA2_COL_BITS +: DATA2_COL_BITS]
                                 & {DATA2_COL_BITS{grant_q[i]}});
        end
        ptr_next = PTR_W'((int'(g_idx) + 1) % NUM_REQ);
        rel_g    = |(rel & grant_q);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        done_d  = '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
        tout_d  = tout_q;
`endif
        case (state_q)
            IDLE: begin
                if ((|req) && mm_ready) begin
                    grant_d = pick_oh;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!mm_ready) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (mm_ready) begin
                    done_d  = grant_q;
                    state_d = READOUT;
                end
            end
            READOUT: begin
`ifdef MATMUL_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (rel_g || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    tout_d  = tout_q | ~rel_g;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
`else
                if (rel_g) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
`ifdef MATMUL_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);
    assign mm_start = (state_q == START);
    assign sel_vec  = mm_sel_vec;
    assign sel_row  = mm_sel_row;
    assign sel_col  = mm_sel_col;
    assign data_out = mm_data_out;
`ifdef MATMUL_ARB_TIMEOUT_EN
    assign timeout_err = tout_q;
`endif

endmodule
